// File: rtl/uart_receiver_if.sv
// Serial RX line plus the received-byte stream toward the consumer.
// The receiver drives the byte side (master); the line driver and consumer side is the slave.
interface uart_receiver_if;
   logic       rx;
   logic [7:0] data;
   logic       data_valid;
   logic       frame_err;
   logic       rx_busy;

   modport master (
      input  rx,
      output data,
      output data_valid,
      output frame_err,
      output rx_busy
   );

   modport slave (
      output rx,
      input  data,
      input  data_valid,
      input  frame_err,
      input  rx_busy
   );
endinterface

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: mid-bit sampling, byte strobe one cycle after the stop sample.
// No backpressure: the consumer must take data within one frame time.
module uart_receiver #(
   parameter int p_CLOCKS_PER_BAUD = 868
) (
   input  logic            i_CLK,
   input  logic            i_RESET,
   uart_receiver_if.master rx_bus
);
   localparam int CW = $clog2(p_CLOCKS_PER_BAUD);
   localparam logic [CW-1:0] HALF_LAST = CW'(p_CLOCKS_PER_BAUD / 2 - 1);
   localparam logic [CW-1:0] BAUD_LAST = CW'(p_CLOCKS_PER_BAUD - 1);

   typedef enum logic [1:0] {s_IDLE, s_START, s_DATA, s_STOP} state_t;

   state_t        state;
   logic [CW-1:0] baud_cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shift_reg;
   logic [1:0]    rx_sync;
   logic          rx_s;
   logic          rx_q;
   logic [7:0]    data_r;
   logic          data_valid_r;
   logic          frame_err_r;

   assign rx_s = rx_sync[1];

   always_ff @(posedge i_CLK) begin
      if (i_RESET) begin
         state        <= s_IDLE;
         baud_cnt     <= '0;
         bit_idx      <= '0;
         shift_reg    <= '0;
         rx_sync      <= 2'b11;
         rx_q         <= 1'b1;
         data_r       <= '0;
         data_valid_r <= 1'b0;
         frame_err_r  <= 1'b0;
      end else begin
         rx_sync      <= {rx_sync[0], rx_bus.rx};
         rx_q         <= rx_s;
         data_valid_r <= 1'b0;
         frame_err_r  <= 1'b0;
         case (state)
            s_IDLE: begin
               baud_cnt <= '0;
               // Edge-triggered only, so a line held low (break) cannot retrigger.
               if (rx_q && !rx_s)
                  state <= s_START;
            end
            s_START: begin
               if (baud_cnt == HALF_LAST) begin
                  baud_cnt <= '0;
                  if (!rx_s) begin
                     state   <= s_DATA;
                     bit_idx <= '0;
                  end else begin
                     state <= s_IDLE;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            s_DATA: begin
               if (baud_cnt == BAUD_LAST) begin
                  baud_cnt  <= '0;
                  shift_reg <= {rx_s, shift_reg[7:1]};
                  bit_idx   <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7)
                     state <= s_STOP;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            s_STOP: begin
               if (baud_cnt == BAUD_LAST) begin
                  baud_cnt <= '0;
                  state    <= s_IDLE;
                  if (rx_s) begin
                     data_r       <= shift_reg;
                     data_valid_r <= 1'b1;
                  end else begin
                     frame_err_r <= 1'b1;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            default: state <= s_IDLE;
         endcase
      end
   end

   assign rx_bus.data       = data_r;
   assign rx_bus.data_valid = data_valid_r;
   assign rx_bus.frame_err  = frame_err_r;
   assign rx_bus.rx_busy    = (state != s_IDLE);
endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at 16 clocks per bit, line driven by a bit-accurate model.
module tb_uart_receiver;
   localparam int B = 16;
   localparam int H = B / 2;

   logic i_CLK;
   logic i_RESET;
   int   checks;
   int   errors;
   int   cyc;

   uart_receiver_if ifc ();

   uart_receiver #(.p_CLOCKS_PER_BAUD(B)) dut (
      .i_CLK   (i_CLK),
      .i_RESET (i_RESET),
      .rx_bus  (ifc)
   );

   initial i_CLK = 1'b0;
   always #5 i_CLK = ~i_CLK;

   initial cyc = 0;
   always @(posedge i_CLK) cyc <= cyc + 1;

   // Monitor: cumulative strobe/busy statistics sampled on the falling edge.
   int         valid_cnt;
   int         ferr_cnt;
   int         busy_cnt;
   int         busy_rise;
   int         both_cnt;
   logic       busy_prev;
   logic [7:0] rx_data_q[$];
   int         rx_cyc_q[$];

   initial begin
      valid_cnt = 0;
      ferr_cnt  = 0;
      busy_cnt  = 0;
      busy_rise = 0;
      both_cnt  = 0;
      busy_prev = 1'b0;
   end

   always @(negedge i_CLK) begin
      if (ifc.data_valid === 1'b1) begin
         valid_cnt = valid_cnt + 1;
         rx_data_q.push_back(ifc.data);
         rx_cyc_q.push_back(cyc);
      end
      if (ifc.frame_err === 1'b1) ferr_cnt = ferr_cnt + 1;
      if (ifc.data_valid === 1'b1 && ifc.frame_err === 1'b1) both_cnt = both_cnt + 1;
      if (ifc.rx_busy === 1'b1) busy_cnt = busy_cnt + 1;
      if (ifc.rx_busy === 1'b1 && busy_prev !== 1'b1) busy_rise = busy_rise + 1;
      busy_prev = ifc.rx_busy;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks = checks + 1;
      if (obs !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Each call holds the line for n whole clocks; callers start at posedge+1.
   task automatic drive(input logic v, input int n);
      repeat (n) begin
         ifc.rx = v;
         @(posedge i_CLK);
         #1;
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop);
      drive(1'b0, B);
      for (int i = 0; i < 8; i++) drive(b[i], B);
      drive(stop, B);
   endtask

   int         v0, f0, bc0, br0, q0;
   logic [7:0] exp_q[$];
   logic [7:0] rb;

   initial begin
      checks  = 0;
      errors  = 0;
      i_RESET = 1'b1;
      ifc.rx  = 1'b1;
      repeat (3) @(posedge i_CLK);
      #1;
      check("rst_data", {24'd0, ifc.data}, 32'h00);
      check("rst_valid", {31'd0, ifc.data_valid}, 32'd0);
      check("rst_ferr", {31'd0, ifc.frame_err}, 32'd0);
      check("rst_busy", {31'd0, ifc.rx_busy}, 32'd0);
      i_RESET = 1'b0;
      drive(1'b1, 10);

      // Good frame 0xA5
      v0 = valid_cnt; f0 = ferr_cnt; bc0 = busy_cnt; br0 = busy_rise; q0 = rx_data_q.size();
      send_frame(8'hA5, 1'b1);
      drive(1'b1, 20);
      check("a5_valid_cnt", valid_cnt - v0, 32'd1);
      check("a5_ferr_cnt", ferr_cnt - f0, 32'd0);
      check("a5_data", {24'd0, ifc.data}, 32'hA5);
      check("a5_busy_cycles", busy_cnt - bc0, H + 9 * B);
      check("a5_busy_rises", busy_rise - br0, 32'd1);
      check("a5_q_size", rx_data_q.size() - q0, 32'd1);

      // Short low glitch
      v0 = valid_cnt; f0 = ferr_cnt;
      drive(1'b0, 4);
      drive(1'b1, 40);
      check("glitch_valid", valid_cnt - v0, 32'd0);
      check("glitch_ferr", ferr_cnt - f0, 32'd0);
      check("glitch_busy", {31'd0, ifc.rx_busy}, 32'd0);
      check("glitch_data", {24'd0, ifc.data}, 32'hA5);

      // Framing error followed by a held break
      v0 = valid_cnt; f0 = ferr_cnt; br0 = busy_rise;
      send_frame(8'h3C, 1'b0);
      drive(1'b0, 40);
      drive(1'b1, 40);
      check("ferr_cnt", ferr_cnt - f0, 32'd1);
      check("ferr_valid", valid_cnt - v0, 32'd0);
      check("ferr_data_kept", {24'd0, ifc.data}, 32'hA5);
      check("ferr_no_retrigger", busy_rise - br0, 32'd1);

      // Back-to-back frames, no idle gap
      v0 = valid_cnt; f0 = ferr_cnt; q0 = rx_data_q.size();
      send_frame(8'h00, 1'b1);
      send_frame(8'hFF, 1'b1);
      drive(1'b1, 40);
      check("b2b_valid_cnt", valid_cnt - v0, 32'd2);
      check("b2b_ferr", ferr_cnt - f0, 32'd0);
      if (rx_data_q.size() >= q0 + 2) begin
         check("b2b_first", {24'd0, rx_data_q[q0]}, 32'h00);
         check("b2b_second", {24'd0, rx_data_q[q0+1]}, 32'hFF);
         check("b2b_spacing", rx_cyc_q[q0+1] - rx_cyc_q[q0], 32'd160);
      end

      // Reset in the middle of 0x81, then a clean 0x5A
      v0 = valid_cnt; f0 = ferr_cnt;
      drive(1'b0, B);
      for (int i = 0; i < 4; i++) drive(rb_bit(8'h81, i), B);
      i_RESET = 1'b1;
      ifc.rx  = 1'b1;
      @(posedge i_CLK);
      #1;
      check("midrst_data", {24'd0, ifc.data}, 32'h00);
      check("midrst_busy", {31'd0, ifc.rx_busy}, 32'd0);
      check("midrst_valid", {31'd0, ifc.data_valid}, 32'd0);
      check("midrst_ferr", {31'd0, ifc.frame_err}, 32'd0);
      i_RESET = 1'b0;
      drive(1'b1, 40);
      check("midrst_no_strobe", (valid_cnt - v0) + (ferr_cnt - f0), 32'd0);
      v0 = valid_cnt;
      send_frame(8'h5A, 1'b1);
      drive(1'b1, 20);
      check("post_rst_valid", valid_cnt - v0, 32'd1);
      check("post_rst_data", {24'd0, ifc.data}, 32'h5A);

      // Random stream with small random idle gaps
      f0 = ferr_cnt; q0 = rx_data_q.size();
      for (int i = 0; i < 256; i++) begin
         rb = 8'($urandom_range(0, 255));
         exp_q.push_back(rb);
         send_frame(rb, 1'b1);
         drive(1'b1, int'($urandom_range(0, 3)));
      end
      drive(1'b1, 40);
      check("stream_count", rx_data_q.size() - q0, 32'd256);
      check("stream_ferr", ferr_cnt - f0, 32'd0);
      if (rx_data_q.size() >= q0 + 256)
         for (int i = 0; i < 256; i++)
            check("stream_byte", {24'd0, rx_data_q[q0+i]}, {24'd0, exp_q[i]});
      check("never_both", both_cnt, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   function automatic logic rb_bit(input logic [7:0] b, input int i);
      return b[i];
   endfunction
endmodule
